// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts bytes over a valid/ready handshake and
// shifts each out LSB first as start, data, optional parity and stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS);
    localparam logic       PAR_INIT  = (PARITY_ODD != 0);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] hold_reg, hold_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 pending, pending_n;
    logic                 par_bit, par_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [1:0]           stop_cnt, stop_cnt_n;
    logic                 tx_n, ready_n, busy_n;
    logic                 transfer, last_stop;
    logic [DATA_BITS-1:0] load_src;

    assign transfer  = tx_valid && tx_ready;
    assign last_stop = (state == STOP) && (stop_cnt == LAST_STOP);
    // A byte accepted on the frame-ending tick bypasses the hold register.
    assign load_src  = pending ? hold_reg : tx_data;

    always_comb begin
        state_n    = state;
        hold_n     = hold_reg;
        shift_n    = shift_reg;
        pending_n  = pending;
        par_n      = par_bit;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        tx_n       = tx;

        if (transfer && !(last_stop && baud_tick)) begin
            hold_n    = tx_data;
            pending_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (transfer) begin
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (baud_tick) begin
                    tx_n      = 1'b0;
                    shift_n   = load_src;
                    par_n     = (^load_src) ^ PAR_INIT;
                    pending_n = 1'b0;
                    state_n   = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_n      = shift_reg[0];
                    shift_n   = shift_reg >> 1;
                    bit_cnt_n = 4'd1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt != LAST_DATA) begin
                        tx_n      = shift_reg[0];
                        shift_n   = shift_reg >> 1;
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (PARITY_EN != 0) begin
                        tx_n    = par_bit;
                        state_n = PARITY;
                    end else begin
                        tx_n       = 1'b1;
                        stop_cnt_n = 2'd1;
                        state_n    = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 2'd1;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt != LAST_STOP) begin
                        stop_cnt_n = stop_cnt + 2'd1;
                    end else if (pending || transfer) begin
                        tx_n      = 1'b0;
                        shift_n   = load_src;
                        par_n     = (^load_src) ^ PAR_INIT;
                        pending_n = 1'b0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Ready is registered, so it is derived from where the FSM is heading.
        ready_n = (state_n == IDLE) ||
                  ((state_n == STOP) && (stop_cnt_n == LAST_STOP) && !pending_n);
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            pending   <= 1'b0;
            par_bit   <= 1'b0;
            bit_cnt   <= 4'd0;
            stop_cnt  <= 2'd0;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_reg  <= hold_n;
            shift_reg <= shift_n;
            pending   <= pending_n;
            par_bit   <= par_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            tx        <= tx_n;
            tx_ready  <= ready_n;
            tx_busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four framings (8N1, 8E1, 8O1, 8N2) share a
// clock, reset and baud strobe; a serial-line monitor scores decoded frames.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] txl;
    logic [3:0] busy;
    logic [7:0] data [4];

    int   checks;
    int   passed;
    int   cyc;
    int   sel;
    bit   mon_en;
    int   frames_done;
    int   hs_cnt;
    exp_t exp_q[$];
    int   start_q[$];

    int   pe [4] = '{0, 1, 1, 0};
    int   sb [4] = '{1, 1, 1, 2};

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[0]),
        .tx_valid(valid[0]), .tx_ready(ready[0]), .tx(txl[0]), .tx_busy(busy[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[1]),
        .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(txl[1]), .tx_busy(busy[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[2]),
        .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(txl[2]), .tx_busy(busy[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[3]),
        .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(txl[3]), .tx_busy(busy[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Free-running 1x baud strobe, one clk wide every 16 clocks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Handshakes are counted once inputs have settled after the negedge.
    initial begin
        hs_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (valid[d] && ready[d] && rst_n) hs_cnt = hs_cnt + 1;
            end
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act == exp) passed = passed + 1;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic report_timeout(input string name);
        checks = checks + 1;
        $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    // Decodes frames on the selected line, sampling mid-bit.
    initial begin
        int         s;
        logic       start_bit;
        logic [7:0] dbits;
        logic       pbit;
        logic       stop_ok;
        exp_t       e;
        frames_done = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txl[sel] == 1'b0) begin
                s = sel;
                start_q.push_back(cyc);
                repeat (8) @(negedge clk);
                start_bit = txl[s];
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    dbits[i] = txl[s];
                end
                pbit = 1'b0;
                if (pe[s] != 0) begin
                    repeat (16) @(negedge clk);
                    pbit = txl[s];
                end
                stop_ok = 1'b1;
                for (int i = 0; i < sb[s]; i++) begin
                    repeat (16) @(negedge clk);
                    stop_ok = stop_ok & txl[s];
                end
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    $display("[TB] FAIL unexpected_frame: got data 0x%02h, expected no frame", dbits);
                end else begin
                    e = exp_q.pop_front();
                    check_output("start_bit", int'(start_bit), 0);
                    check_output("frame_data", int'(dbits), int'(e.data));
                    if (pe[s] != 0) check_output("parity_bit", int'(pbit), int'(e.par));
                    check_output("stop_bits", int'(stop_ok), 1);
                end
                frames_done = frames_done + 1;
            end
        end
    end

    task automatic apply_stimulus(input int d, input logic [7:0] b, input logic par,
                                  input bit push, input bit hold, output int acc);
        int n;
        if (!valid[d]) @(negedge clk);
        data[d]  = b;
        valid[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!ready[d]) begin
            report_timeout("handshake");
            valid[d] = 1'b0;
        end else begin
            if (push) exp_q.push_back('{data: b, par: par});
            @(negedge clk);
            if (!hold) valid[d] = 1'b0;
        end
    endtask

    task automatic wait_tx_low(input int d, output int c);
        int n = 0;
        while (txl[d] != 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        if (txl[d] != 1'b0) report_timeout("start_edge");
    endtask

    task automatic measure_frame(input int d, input int len);
        int c0, c1, n;
        wait_tx_low(d, c0);
        n = 0;
        while (busy[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        c1 = cyc;
        if (busy[d]) report_timeout("busy_fall");
        else check_output("frame_length_clk", c1 - c0, len * 16);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) report_timeout("frame_decode");
    endtask

    task automatic run_b2b(input int d, input logic [7:0] b1, input logic [7:0] b2,
                           input int len);
        int fd0, hs0, acc;
        sel = d;
        fd0 = frames_done;
        hs0 = hs_cnt;
        apply_stimulus(d, b1, 1'b0, 1'b1, 1'b1, acc);
        apply_stimulus(d, b2, 1'b0, 1'b1, 1'b0, acc);
        wait_frames(fd0 + 2);
        if (start_q.size() >= 2)
            check_output("b2b_start_gap", start_q[start_q.size()-1] - start_q[start_q.size()-2], len * 16);
        check_output("b2b_handshakes", hs_cnt - hs0, 2);
        repeat (20) @(negedge clk);
        check_output("b2b_idle_busy", int'(busy[d]), 0);
    endtask

    initial begin
        vec_t tbl [7];
        int   fd0, hs0, acc, c0;

        checks = 0;
        passed = 0;
        sel    = 0;
        mon_en = 1'b1;
        rst_n  = 1'b0;
        valid  = 4'b0000;
        for (int d = 0; d < 4; d++) data[d] = 8'h00;

        tbl[0] = '{0, 8'h55, 1'b0, 10};
        tbl[1] = '{1, 8'h07, 1'b1, 11};
        tbl[2] = '{2, 8'h07, 1'b0, 11};
        tbl[3] = '{3, 8'hFF, 1'b0, 11};
        tbl[4] = '{1, 8'hA0, 1'b0, 11};
        tbl[5] = '{2, 8'hA0, 1'b1, 11};
        tbl[6] = '{0, 8'h00, 1'b0, 10};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_output("reset_tx", int'(txl[d]), 1);
            check_output("reset_ready", int'(ready[d]), 1);
            check_output("reset_busy", int'(busy[d]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sel = tbl[i].sel;
            fd0 = frames_done;
            apply_stimulus(tbl[i].sel, tbl[i].data, tbl[i].exp_par, 1'b1, 1'b0, acc);
            measure_frame(tbl[i].sel, tbl[i].exp_len);
            wait_frames(fd0 + 1);
            check_output("post_frame_ready", int'(ready[tbl[i].sel]), 1);
            check_output("post_frame_busy", int'(busy[tbl[i].sel]), 0);
            repeat (5) @(negedge clk);
        end

        $display("[TB] back-to-back 8N1 and 8N2");
        run_b2b(0, 8'hA5, 8'h3C, 10);
        run_b2b(3, 8'hFF, 8'h00, 11);

        $display("[TB] busy stall");
        sel = 0;
        fd0 = frames_done;
        hs0 = hs_cnt;
        apply_stimulus(0, 8'h34, 1'b0, 1'b1, 1'b0, acc);
        wait_tx_low(0, c0);
        repeat (48) @(negedge clk);
        check_output("stall_ready_in_data", int'(ready[0]), 0);
        apply_stimulus(0, 8'h12, 1'b0, 1'b1, 1'b0, acc);
        check_output("stall_accept_offset", acc - c0, 144);
        wait_frames(fd0 + 2);
        check_output("stall_handshakes", hs_cnt - hs0, 2);
        repeat (300) @(negedge clk);
        check_output("stall_frame_count", frames_done - fd0, 2);
        check_output("stall_queue_left", exp_q.size(), 0);
        check_output("stall_busy_end", int'(busy[0]), 0);

        $display("[TB] reset mid-frame");
        mon_en = 1'b0;
        apply_stimulus(0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        wait_tx_low(0, c0);
        repeat (68) @(negedge clk);
        check_output("pre_reset_tx", int'(txl[0]), 0);
        check_output("pre_reset_busy", int'(busy[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_tx", int'(txl[0]), 1);
        check_output("async_reset_ready", int'(ready[0]), 1);
        check_output("async_reset_busy", int'(busy[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        fd0 = frames_done;
        apply_stimulus(0, 8'h81, 1'b0, 1'b1, 1'b0, acc);
        measure_frame(0, 10);
        wait_frames(fd0 + 1);
        check_output("after_reset_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
